// File: rtl/mc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mc_pkg : shared types and constants for motion-compensated reconstruction |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package mc_pkg;

  localparam int MC_MB_SIZE        = 4;
  localparam int MC_PIXEL_WIDTH    = 8;
  localparam int MC_REF_FRAME_SIZE = 8;

  localparam int PIX_MAX = (1 << MC_PIXEL_WIDTH) - 1;

  typedef logic        [MC_PIXEL_WIDTH-1:0] pixel_t;
  typedef logic signed [MC_PIXEL_WIDTH:0]   residual_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_REF_WAIT = 3'd2,
    S_RES      = 3'd3,
    S_OUT      = 3'd4,
    S_DONE     = 3'd5
  } mc_rec_state_t;

  function automatic int pix_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_row_clip_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mc_row_clip_add : per-pixel signed add of residual to prediction, then    |
// | saturation to the unsigned pixel range. Purely combinational.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mc_row_clip_add
  import mc_pkg::*;
#(
  parameter int MB_SIZE     = MC_MB_SIZE,
  parameter int PIXEL_WIDTH = MC_PIXEL_WIDTH
) (
  input  logic [MB_SIZE*PIXEL_WIDTH-1:0]     pred_i,
  input  logic [MB_SIZE*(PIXEL_WIDTH+1)-1:0] res_i,
  output logic [MB_SIZE*PIXEL_WIDTH-1:0]     sum_o
);

  localparam int c_PIX_MAX = pix_max(PIXEL_WIDTH);

  for (genvar i = 0; i < MB_SIZE; i++) begin : g_pix
    logic        [PIXEL_WIDTH-1:0] w_p;
    logic        [PIXEL_WIDTH:0]   w_r;
    logic signed [PIXEL_WIDTH+1:0] w_s;

    assign w_p = pred_i[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign w_r = res_i[i*(PIXEL_WIDTH+1) +: PIXEL_WIDTH+1];
    assign w_s = $signed({2'b00, w_p}) + $signed({w_r[PIXEL_WIDTH], w_r});

    // Sign bit set -> below zero; bit PIXEL_WIDTH set on a positive sum -> above max.
    assign sum_o[i*PIXEL_WIDTH +: PIXEL_WIDTH] =
        w_s[PIXEL_WIDTH+1] ? '0 :
        w_s[PIXEL_WIDTH]   ? PIXEL_WIDTH'(c_PIX_MAX) :
                             w_s[PIXEL_WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/mc_reconstruction.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mc_reconstruction : rebuilds one macroblock row by row from a clamped     |
// | reference fetch plus residual, with valid/ready on both row streams.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mc_reconstruction
  import mc_pkg::*;
#(
  parameter int MB_SIZE        = MC_MB_SIZE,
  parameter int PIXEL_WIDTH    = MC_PIXEL_WIDTH,
  parameter int REF_FRAME_SIZE = MC_REF_FRAME_SIZE
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [5:0]                             mv_x,
  input  logic [5:0]                             mv_y,
  input  logic [$clog2(REF_FRAME_SIZE)-1:0]      mb_x,
  input  logic [$clog2(REF_FRAME_SIZE)-1:0]      mb_y,
  output logic                                   busy,
  output logic                                   ref_rd_en,
  output logic [$clog2(REF_FRAME_SIZE)-1:0]      ref_rd_y,
  output logic [$clog2(REF_FRAME_SIZE)-1:0]      ref_rd_x,
  input  logic [MB_SIZE*PIXEL_WIDTH-1:0]         ref_rd_data,
  input  logic                                   res_valid,
  output logic                                   res_ready,
  input  logic [MB_SIZE*(PIXEL_WIDTH+1)-1:0]     res_row,
  output logic                                   recon_valid,
  input  logic                                   recon_ready,
  output logic [MB_SIZE*PIXEL_WIDTH-1:0]         recon_row,
  output logic                                   recon_last,
  output logic                                   done
);

  localparam int AW = $clog2(REF_FRAME_SIZE);
  localparam int RW = (MB_SIZE > 1) ? $clog2(MB_SIZE) : 1;
  // Wide enough for mb + mv + row over the full -32..31 vector range.
  localparam int SW = ((AW > 6) ? AW : 6) + 3;

  localparam logic [SW-1:0] c_Y_MAX   = SW'(REF_FRAME_SIZE - 1);
  localparam logic [SW-1:0] c_X_MAX   = SW'(REF_FRAME_SIZE - MB_SIZE);
  localparam logic [RW-1:0] c_LAST_ROW = RW'(MB_SIZE - 1);

  mc_rec_state_t state_q, state_d;

  logic [5:0]                       mvx_q, mvy_q;
  logic [AW-1:0]                    mbx_q, mby_q;
  logic [RW-1:0]                    row_q;
  logic [AW-1:0]                    ref_y_q, ref_x_q;
  logic [MB_SIZE*PIXEL_WIDTH-1:0]   pred_q;
  logic [MB_SIZE*PIXEL_WIDTH-1:0]   recon_row_q;
  logic                             recon_last_q;

  logic                             w_load_addr, w_res_hs, w_out_hs, w_idle, w_is_last;
  logic [5:0]                       w_src_mvx, w_src_mvy;
  logic [AW-1:0]                    w_src_mbx, w_src_mby;
  logic [RW-1:0]                    w_src_row;
  logic [SW-1:0]                    w_sum_y, w_sum_x;
  logic [MB_SIZE*PIXEL_WIDTH-1:0]   w_clip_row;

  function automatic logic [AW-1:0] clamp_addr(input logic [SW-1:0] v,
                                               input logic [SW-1:0] hi);
    if (v[SW-1])
      return '0;
    else if (v > hi)
      return hi[AW-1:0];
    else
      return v[AW-1:0];
  endfunction

  assign w_idle    = (state_q == S_IDLE);
  assign w_is_last = (row_q == c_LAST_ROW);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    w_load_addr = 1'b0;
    w_res_hs    = 1'b0;
    w_out_hs    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          w_load_addr = 1'b1;
        end
      end
      S_FETCH:    state_d = S_REF_WAIT;
      S_REF_WAIT: state_d = S_RES;
      S_RES: begin
        if (res_valid) begin
          state_d  = S_OUT;
          w_res_hs = 1'b1;
        end
      end
      S_OUT: begin
        if (recon_ready) begin
          w_out_hs = 1'b1;
          if (w_is_last) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_FETCH;
            w_load_addr = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // First row takes its geometry straight from the ports; later rows from the latched copy.
  assign w_src_mvx = w_idle ? mv_x : mvx_q;
  assign w_src_mvy = w_idle ? mv_y : mvy_q;
  assign w_src_mbx = w_idle ? mb_x : mbx_q;
  assign w_src_mby = w_idle ? mb_y : mby_q;
  assign w_src_row = w_idle ? '0 : row_q + RW'(1);

  assign w_sum_y = {{(SW-AW){1'b0}}, w_src_mby} + {{(SW-6){w_src_mvy[5]}}, w_src_mvy}
                 + {{(SW-RW){1'b0}}, w_src_row};
  assign w_sum_x = {{(SW-AW){1'b0}}, w_src_mbx} + {{(SW-6){w_src_mvx[5]}}, w_src_mvx};

  mc_row_clip_add #(
    .MB_SIZE     (MB_SIZE),
    .PIXEL_WIDTH (PIXEL_WIDTH)
  ) u_clip_add (
    .pred_i (pred_q),
    .res_i  (res_row),
    .sum_o  (w_clip_row)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mvx_q        <= '0;
      mvy_q        <= '0;
      mbx_q        <= '0;
      mby_q        <= '0;
      row_q        <= '0;
      ref_y_q      <= '0;
      ref_x_q      <= '0;
      pred_q       <= '0;
      recon_row_q  <= '0;
      recon_last_q <= 1'b0;
    end else begin
      if (w_load_addr) begin
        row_q   <= w_src_row;
        ref_y_q <= clamp_addr(w_sum_y, c_Y_MAX);
        ref_x_q <= clamp_addr(w_sum_x, c_X_MAX);
        if (w_idle) begin
          mvx_q <= mv_x;
          mvy_q <= mv_y;
          mbx_q <= mb_x;
          mby_q <= mb_y;
        end
      end
      if (state_q == S_REF_WAIT)
        pred_q <= ref_rd_data;
      if (w_res_hs) begin
        recon_row_q  <= w_clip_row;
        recon_last_q <= w_is_last;
      end else if (w_out_hs) begin
        recon_last_q <= 1'b0;
      end
    end
  end

  assign busy        = !w_idle;
  assign ref_rd_en   = (state_q == S_FETCH);
  assign ref_rd_y    = ref_y_q;
  assign ref_rd_x    = ref_x_q;
  assign res_ready   = (state_q == S_RES);
  assign recon_valid = (state_q == S_OUT);
  assign recon_row   = recon_row_q;
  assign recon_last  = recon_last_q;
  assign done        = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mc_reconstruction.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mc_reconstruction : self-checking bench with reference frame memory,   |
// | address/pixel reference model and multi-cycle corner sequences.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mc_reconstruction;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  mv_x, mv_y;
  logic [2:0]  mb_x, mb_y;
  logic        busy, ref_rd_en;
  logic [2:0]  ref_rd_y, ref_rd_x;
  logic [31:0] ref_rd_data;
  logic        res_valid, res_ready;
  logic [35:0] res_row;
  logic        recon_valid, recon_ready;
  logic [31:0] recon_row;
  logic        recon_last, done;

  mc_reconstruction #(.MB_SIZE(4), .PIXEL_WIDTH(8), .REF_FRAME_SIZE(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mv_x        (mv_x),
    .mv_y        (mv_y),
    .mb_x        (mb_x),
    .mb_y        (mb_y),
    .busy        (busy),
    .ref_rd_en   (ref_rd_en),
    .ref_rd_y    (ref_rd_y),
    .ref_rd_x    (ref_rd_x),
    .ref_rd_data (ref_rd_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_row     (res_row),
    .recon_valid (recon_valid),
    .recon_ready (recon_ready),
    .recon_row   (recon_row),
    .recon_last  (recon_last),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mbx, mby, mvx, mvy;
    int ex;
    int ey[4];
  } vec_t;

  logic [7:0]  mem [8][8];
  int          res_tab [4][4];
  int          n_checks = 0;
  int          n_pass   = 0;

  logic [31:0] obs_rows [8];
  logic        obs_last [8];
  int          obs_y [8];
  int          obs_x [8];
  int          nrows, nfetch, ndone, first_fetch, done_cyc, res_idx;

  // Reference frame memory: one-cycle read latency.
  always @(posedge clk) begin
    if (ref_rd_en) begin
      for (int i = 0; i < 4; i++)
        ref_rd_data[i*8 +: 8] <= (int'(ref_rd_x) + i < 8) ? mem[ref_rd_y][int'(ref_rd_x) + i] : 8'h00;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic logic [31:0] model_row(input vec_t v, input int r);
    logic [31:0] p;
    int y, x, s;
    y = clampi(v.mby + v.mvy + r, 0, 7);
    x = clampi(v.mbx + v.mvx, 0, 4);
    for (int i = 0; i < 4; i++) begin
      s = int'(mem[y][x+i]) + res_tab[r][i];
      p[i*8 +: 8] = 8'(clampi(s, 0, 255));
    end
    return p;
  endfunction

  function automatic logic [35:0] pack_res(input int r);
    logic [35:0] p;
    for (int i = 0; i < 4; i++) p[i*9 +: 9] = 9'(res_tab[r][i]);
    return p;
  endfunction

  task automatic fill_linear();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) mem[y][x] = 8'(8*y + x);
  endtask

  task automatic fill_random();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) mem[y][x] = 8'($urandom_range(0, 255));
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++) res_tab[r][i] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic zero_res();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 4; i++) res_tab[r][i] = 0;
  endtask

  task automatic run_mb(input vec_t v, input int stall_row, input int stall_n,
                        input int busy_row, input int abort_row);
    int  cyc, out_idx, stall_cnt, post;
    bit  hs_res, hs_out;
    nrows = 0; nfetch = 0; ndone = 0; res_idx = 0;
    first_fetch = -1; done_cyc = -1;
    cyc = 0; out_idx = 0; stall_cnt = 0; post = 0;
    hs_res = 0; hs_out = 0;
    @(posedge clk); #1;
    mb_x = 3'(v.mbx); mb_y = 3'(v.mby); mv_x = 6'(v.mvx); mv_y = 6'(v.mvy);
    start = 1'b1;
    res_valid = 1'b1;
    res_row = pack_res(0);
    recon_ready = !(stall_row == 0 && stall_n > 0);
    while (cyc < 200 && post < 8) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (hs_res) begin
        res_idx++;
        res_row = pack_res(res_idx > 3 ? 3 : res_idx);
      end
      if (hs_out) begin
        out_idx++;
        if (out_idx == busy_row) begin
          start = 1'b1;
          mv_x = 6'(v.mvx + 2);
          mv_y = 6'(v.mvy + 1);
        end
      end
      recon_ready = !(out_idx == stall_row && stall_cnt < stall_n);
      @(negedge clk);
      hs_res = res_valid && res_ready;
      hs_out = recon_valid && recon_ready;
      if (ref_rd_en) begin
        if (first_fetch < 0) first_fetch = cyc;
        if (nfetch < 8) begin
          obs_y[nfetch] = int'(ref_rd_y);
          obs_x[nfetch] = int'(ref_rd_x);
        end
        nfetch++;
      end
      if (hs_out && nrows < 8) begin
        obs_rows[nrows] = recon_row;
        obs_last[nrows] = recon_last;
        nrows++;
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (ndone > 0) post++;
      if (recon_valid && !recon_ready) begin
        check($sformatf("stall_row_r%0d_c%0d", out_idx, stall_cnt), recon_row, model_row(v, out_idx));
        check($sformatf("stall_res_ready_c%0d", stall_cnt), res_ready, 1'b0);
        check($sformatf("stall_ref_rd_en_c%0d", stall_cnt), ref_rd_en, 1'b0);
        stall_cnt++;
      end
      if (abort_row >= 0 && res_ready && out_idx == abort_row) begin
        reset = 1'b0;
        #1;
        check("abort_outputs_zero",
              {busy, ref_rd_en, ref_rd_y, ref_rd_x, res_ready, recon_valid, recon_row, recon_last, done},
              '0);
        res_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        recon_ready = 1'b1;
        return;
      end
    end
    res_valid = 1'b0;
    recon_ready = 1'b1;
    check("run_within_budget", (cyc < 200), 1'b1);
  endtask

  task automatic verify_mb(input string nm, input vec_t v, input int stalls);
    check({nm, "_nrows"}, nrows, 4);
    check({nm, "_nfetch"}, nfetch, 4);
    check({nm, "_ndone"}, ndone, 1);
    check({nm, "_first_fetch"}, first_fetch, 1);
    check({nm, "_done_cycle"}, done_cyc, 17 + stalls);
    check({nm, "_busy_end"}, busy, 1'b0);
    for (int r = 0; r < 4; r++) begin
      if (r < nrows) begin
        check($sformatf("%s_row%0d", nm, r), obs_rows[r], model_row(v, r));
        check($sformatf("%s_last%0d", nm, r), obs_last[r], (r == 3));
      end
      if (r < nfetch) begin
        check($sformatf("%s_ref_y%0d", nm, r), obs_y[r], v.ey[r]);
        check($sformatf("%s_ref_x%0d", nm, r), obs_x[r], v.ex);
      end
    end
  endtask

  task automatic set_vec(output vec_t v, input int mbx, mby, mvx, mvy, ex,
                         input int y0, y1, y2, y3);
    v.mbx = mbx; v.mby = mby; v.mvx = mvx; v.mvy = mvy; v.ex = ex;
    v.ey[0] = y0; v.ey[1] = y1; v.ey[2] = y2; v.ey[3] = y3;
  endtask

  task automatic check_unit_rows(input string nm);
    logic [31:0] unit_exp [4];
    unit_exp[0] = 32'h0C0B0A09;
    unit_exp[1] = 32'h14131211;
    unit_exp[2] = 32'h1C1B1A19;
    unit_exp[3] = 32'h24232221;
    for (int r = 0; r < 4; r++)
      check($sformatf("%s_const_row%0d", nm, r), obs_rows[r], unit_exp[r]);
  endtask

  vec_t tab [6];
  vec_t unit_v, clip_v;

  initial begin
    reset = 1'b0; start = 1'b0; mv_x = '0; mv_y = '0; mb_x = '0; mb_y = '0;
    res_valid = 1'b0; res_row = '0; recon_ready = 1'b1;
    fill_linear();
    zero_res();

    repeat (2) @(negedge clk);
    check("reset_outputs_zero",
          {busy, ref_rd_en, ref_rd_y, ref_rd_x, res_ready, recon_valid, recon_row, recon_last, done},
          '0);
    @(posedge clk); #1;
    reset = 1'b1;

    set_vec(tab[0], 0, 0,  1,   1, 1, 1, 2, 3, 4);
    set_vec(tab[1], 4, 0,  7,  -2, 4, 0, 0, 0, 1);
    set_vec(tab[2], 0, 0, -5, -32, 0, 0, 0, 0, 0);
    set_vec(tab[3], 7, 7, 31,  31, 4, 7, 7, 7, 7);
    set_vec(tab[4], 3, 5, -1,   1, 2, 6, 7, 7, 7);
    set_vec(tab[5], 2, 3, -1,  -3, 1, 0, 1, 2, 3);
    unit_v = tab[0];

    // Unit case: linear frame, zero residual.
    run_mb(unit_v, -1, 0, -1, -1);
    verify_mb("unit", unit_v, 0);
    check_unit_rows("unit");

    // Table of geometries with random frame and residual.
    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_mb(tab[k], -1, 0, -1, -1);
      verify_mb($sformatf("vec%0d", k), tab[k], 0);
    end

    // Saturation at both ends of the pixel range.
    fill_random();
    mem[0][0] = 8'd250; mem[0][1] = 8'd5; mem[0][2] = 8'd128; mem[0][3] = 8'd0;
    res_tab[0][0] = 10; res_tab[0][1] = -20; res_tab[0][2] = -128; res_tab[0][3] = 255;
    set_vec(clip_v, 0, 0, 0, 0, 0, 0, 1, 2, 3);
    run_mb(clip_v, -1, 0, -1, -1);
    verify_mb("clip", clip_v, 0);
    check("clip_const_row0", obs_rows[0], 32'hFF0000FF);

    // Backpressure on row 1.
    fill_random();
    run_mb(tab[4], 1, 3, -1, -1);
    verify_mb("stall", tab[4], 3);

    // Start pulse while busy is ignored.
    fill_random();
    run_mb(tab[1], -1, 0, 1, -1);
    verify_mb("busy_start", tab[1], 0);

    // Reset during RES of row 2, then the unit case again.
    fill_linear();
    zero_res();
    run_mb(unit_v, -1, 0, -1, 2);
    run_mb(unit_v, -1, 0, -1, -1);
    verify_mb("post_reset", unit_v, 0);
    check_unit_rows("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_reconstruction.md
Name: mc_reconstruction

Overview:
- Decoder-side counterpart of motion_compensation: rebuilds a predicted macroblock from reference frame plus residual, row by row.
- Reconstruction rule: recon = clip(ref_pred + residual).
- Fetches one MB_SIZE-pixel reference row segment per row from reference frame memory at (mb + mv) with edge clamping.
- Accepts one residual row per handshake and emits one reconstructed row per handshake; sits between the inverse-transform output and the decoded frame buffer.

Parameters:
- MB_SIZE, 4, macroblock edge in pixels.
- PIXEL_WIDTH, 8, unsigned pixel width.
- REF_FRAME_SIZE, 8, reference frame edge in pixels (square).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to reconstruct one MB; ignored while busy.
- mv_x  in  6  signed two's-complement horizontal motion vector (-32..31), latched on accepted start.
- mv_y  in  6  signed vertical motion vector, latched on accepted start.
- mb_x  in  $clog2(REF_FRAME_SIZE)  MB left column in frame, latched on start.
- mb_y  in  $clog2(REF_FRAME_SIZE)  MB top row in frame, latched on start.
- busy  out  1  high from the cycle after an accepted start until done.
- ref_rd_en  out  1  reference memory read strobe.
- ref_rd_y  out  $clog2(REF_FRAME_SIZE)  reference row address.
- ref_rd_x  out  $clog2(REF_FRAME_SIZE)  reference first-column address.
- ref_rd_data  in  MB_SIZE*PIXEL_WIDTH  pixels x..x+MB_SIZE-1, valid exactly 1 cycle after ref_rd_en; pixel 0 in the LSBs.
- res_valid  in  1  residual row valid.
- res_ready  out  1  block can accept a residual row.
- res_row  in  MB_SIZE*(PIXEL_WIDTH+1)  signed residuals, element 0 in the LSBs.
- recon_valid  out  1  reconstructed row valid.
- recon_ready  in  1  sink accepts the row.
- recon_row  out  MB_SIZE*PIXEL_WIDTH  reconstructed pixels.
- recon_last  out  1  qualifies the final row (row MB_SIZE-1) while recon_valid is high.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset (async, reset=0): state IDLE, row counter 0. All outputs 0: busy, ref_rd_en, ref_rd_y, ref_rd_x, res_ready, recon_valid, recon_row, recon_last, done.
- Reset mid-operation: the row in progress is abandoned and no done pulse is produced.
- FSM states: IDLE, FETCH, REF_WAIT, RES, OUT, DONE.
- IDLE: on start=1, latch mv and mb, row=0, go to FETCH.
- FETCH (1 cycle): ref_rd_en=1 with registered addresses, then REF_WAIT.
  - ref_rd_y = clamp(mb_y+mv_y+row, 0, REF_FRAME_SIZE-1).
  - ref_rd_x = clamp(mb_x+mv_x, 0, REF_FRAME_SIZE-MB_SIZE).
  - Compute both with signed intermediates at least $clog2(REF_FRAME_SIZE)+3 bits wide; no wrap-around allowed.
- REF_WAIT (1 cycle): latch ref_rd_data into the prediction register, then RES.
- RES: res_ready=1. On res_valid&&res_ready, compute per pixel sum = signed(ref) + res.
  - Clip the sum to [0, 2^PIXEL_WIDTH-1].
  - Register the result into recon_row, set recon_valid=1, set recon_last=(row==MB_SIZE-1), go to OUT.
  - res_ready is 0 in every other state.
- OUT: hold recon_row, recon_valid and recon_last stable until recon_ready.
  - On handshake: recon_valid=0.
  - If last row: go to DONE.
  - Otherwise row++ and go to FETCH.
  - recon_ready asserted in the same cycle recon_valid rises counts as a handshake at that edge.
- DONE (1 cycle): done=1, busy=0 on the next cycle, return to IDLE. A start seen in DONE is ignored.
- Latency: start to first FETCH is 1 cycle. With zero stalls a row takes 4 cycles: FETCH, REF_WAIT, RES, OUT.
- recon_row only changes on a RES handshake.

Decomposition:
- Package mc_pkg: state enum mc_rec_state_t, pixel and residual typedefs, and a clip constant PIX_MAX = 2^PIXEL_WIDTH-1.
- Sub-module mc_row_clip_add: combinational MB_SIZE-wide signed add plus saturate. The FSM, address generation and registers stay in the top module.

Test Plan:
- Unit case, frame 8x8 with ref[y][x]=8y+x, mb=(0,0), mv=(1,1), residuals all 0:
  - Reconstructed rows {9,10,11,12}, {17,18,19,20}, {25,26,27,28}, {33,34,35,36}.
  - recon_last is set on row 3 only; done pulses once.
- Clip case: pred row {250,5,128,0}, residual {+10,-20,-128,+255} -> recon {255,0,0,255}.
- Edge clamp case, mb=(4,0), mv=(+7,-2): ref_rd_x=4 for every row; ref_rd_y sequence 0,0,0,1.
- Backpressure case: hold recon_ready=0 for 3 cycles on row 1. recon_row and recon_valid stay stable, res_ready stays 0, and no extra ref_rd_en is issued. The row advances on the first recon_ready=1.
- Reset mid-operation: drive reset=0 while in RES of row 2.
  - All outputs go to 0 immediately, with no done pulse.
  - After release, a new start with the unit case again produces rows {9..12}… correctly.
- Start while busy: pulse start during row 1, which is ignored. Only 4 rows and 1 done are produced.
